lane_scheduler: RTL and testbench
=================================

// Module: lane_scheduler
// PURPOSE
//  Sequences horizontal motion of NUM_LANES car sprites for the freeway game.
//  On each frame_tick (one per VGA frame) it sweeps the lanes one per clock, adding each lane's
//  configured speed to its x position with wrap-around at SCREEN_W. It publishes per-lane x
//  positions consumed by the car sprite renderers. Lane speed and direction are host-configurable.
// PARAMETERS
//  NUM_LANES  4    number of car lanes (>=2, power of two)
//  SCREEN_W   640  visible width in pixels; positions range 0..SCREEN_W-1
//  X_W        10   width of one lane position
//  SPEED_W    4    width of a lane speed (pixels per frame)
// PORTS
//  clk        in   1                   pixel/system clock
//  rst        in   1                   synchronous reset, active-high
//  start      in   1                   pulse: IDLE -> RUN
//  pause      in   1                   level: freeze motion while high
//  frame_tick in   1                   1-cycle pulse per frame (from VGA timing)
//  cfg_we     in   1                   write lane config this cycle
//  cfg_lane   in   $clog2(NUM_LANES)   lane index for cfg write
//  cfg_speed  in   SPEED_W             new speed (0 = stationary)
//  cfg_dir    in   1                   0 = move right (+x), 1 = move left (-x)
//  car_x      out  NUM_LANES*X_W       packed positions, lane i at [i*X_W +: X_W]
//  busy       out  1                   sweep in progress
//  running    out  1                   state is RUN or UPDATE
//  overrun    out  1                   sticky: frame_tick lost
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state IDLE; car_x[i] = i*(SCREEN_W/NUM_LANES); speed[i]=1;
//   dir[i]=0; pending=0; busy=0; running=0; overrun=0. rst overrides all other inputs,
//   including mid-sweep (sweep aborted, no partial update kept).
//  States: IDLE, RUN, UPDATE, PAUSED.
//   IDLE   : frame_tick ignored; start -> RUN.
//   RUN    : pause=1 -> PAUSED (pause wins over same-cycle tick; tick dropped, not pending);
//            else frame_tick -> UPDATE, idx=0.
//   UPDATE : one lane per cycle, lane idx updated at edge, idx++; after lane NUM_LANES-1:
//            pending ? (UPDATE, idx=0, pending=0) : RUN. pause is not sampled until sweep ends.
//   PAUSED : frame_tick ignored; pause=0 -> RUN.
//  start outside IDLE: clears overrun only, no state change.
//  Timing: tick high in cycle before edge T -> UPDATE entered at T; lane i written at edge T+1+i;
//   busy high from T through T+NUM_LANES-1 (NUM_LANES cycles); RUN at T+NUM_LANES if no pending.
//  Tick during UPDATE: pending=1. Tick during UPDATE with pending already 1: overrun=1 (sticky
//   until start or rst), tick discarded.
//  Arithmetic (X_W+1 bit intermediate, no truncation before compare):
//   right: s=x+speed; x' = (s>=SCREEN_W) ? s-SCREEN_W : s.
//   left : x' = (x<speed) ? x+SCREEN_W-speed : x-speed.
//   speed 0 -> x unchanged. Result always in 0..SCREEN_W-1.
//  Config: cfg_we accepted in any state except during rst; takes effect next edge.
//   Write to lane being updated in the same cycle: update uses OLD speed/dir, new value stored.
//   Write to a lane not yet swept in current sweep: new value used this sweep.
//  car_x, busy, running, overrun are registered outputs (no combinational path from inputs).
// TESTING
//  1 rst; check car_x = {480,320,160,0}, busy=0, running=0; tick in IDLE -> no change.
//  2 start; lane0 speed=5 dir=0, x=638; one tick -> lane0 x=3; busy high exactly 4 cycles,
//    lane i changes at T+1+i.
//  3 lane1 dir=1 speed=15 x=160 -> after 11 ticks x=635 (160-165+640); speed 0 lane unchanged.
//  4 tick during sweep -> second sweep back-to-back, busy high 8 cycles; third tick in same
//    sweep -> overrun=1, only 2 sweeps applied; start clears overrun.
//  5 pause asserted with same-cycle tick in RUN -> PAUSED, no motion for 3 ticks; release ->
//    next tick moves; pause mid-sweep -> sweep completes then PAUSED.
//  6 cfg write to lane 2 in cycle lane 2 is swept -> old speed used, new speed on next tick;
//    rst at edge T+2 mid-sweep -> all reset values at next cycle.

Source files
------------

// File: rtl/lane_scheduler.sv
// Lane scheduler for the freeway game: on every frame tick it sweeps the car
// lanes one per clock, moving each lane's x position by its configured speed
// (right or left) with wrap-around at the screen edge.
module lane_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int SCREEN_W  = 640,
    parameter int X_W       = 10,
    parameter int SPEED_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pause,
    input  logic                         frame_tick,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_LANES)-1:0] cfg_lane,
    input  logic [SPEED_W-1:0]           cfg_speed,
    input  logic                         cfg_dir,
    output logic [NUM_LANES*X_W-1:0]     car_x,
    output logic                         busy,
    output logic                         running,
    output logic                         overrun
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam int XE_W  = X_W + 1;
    localparam logic [XE_W-1:0]  SCREEN_W_X = XE_W'(SCREEN_W);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2,
        PAUSED = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   pending_q, pending_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   running_q, running_d;
    logic [X_W-1:0]         car_x_q [NUM_LANES];
    logic [X_W-1:0]         car_x_d [NUM_LANES];
    logic [SPEED_W-1:0]     speed_q [NUM_LANES];
    logic [SPEED_W-1:0]     speed_d [NUM_LANES];
    logic [NUM_LANES-1:0]   dir_q, dir_d;

    logic [XE_W-1:0]        cur_x;
    logic [XE_W-1:0]        cur_speed;
    logic [XE_W-1:0]        sum_right;
    logic [X_W-1:0]         next_x;

    // Wrapped position of the lane currently addressed by the sweep index (uses stored speed/dir).
    always_comb begin
        cur_x     = {1'b0, car_x_q[idx_q]};
        cur_speed = XE_W'(speed_q[idx_q]);
        sum_right = cur_x + cur_speed;
        if (!dir_q[idx_q]) begin
            next_x = (sum_right >= SCREEN_W_X) ? X_W'(sum_right - SCREEN_W_X) : X_W'(sum_right);
        end else begin
            next_x = (cur_x < cur_speed) ? X_W'(cur_x + SCREEN_W_X - cur_speed) : X_W'(cur_x - cur_speed);
        end
    end

    // Sequencer next-state, sweep bookkeeping, lane position writes and host config writes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        car_x_d   = car_x_q;
        speed_d   = speed_q;
        dir_d     = dir_q;

        if (start) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if (frame_tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                car_x_d[idx_q] = next_x;
                if (frame_tick) begin
                    if (pending_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    pending_d = 1'b0;
                    if (pending_q || frame_tick) begin
                        idx_d = '0;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cfg_we) begin
            speed_d[cfg_lane] = cfg_speed;
            dir_d[cfg_lane]   = cfg_dir;
        end
    end

    // Status outputs are computed from the next state so they come straight out of flops.
    always_comb begin
        busy_d    = (state_d == UPDATE);
        running_d = (state_d == RUN) || (state_d == UPDATE);
    end

    // State and datapath registers; reset aborts any sweep and restores the start layout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            running_q <= 1'b0;
            dir_q     <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                car_x_q[i] <= X_W'(i * (SCREEN_W / NUM_LANES));
                speed_q[i] <= SPEED_W'(1);
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            running_q <= running_d;
            dir_q     <= dir_d;
            car_x_q   <= car_x_d;
            speed_q   <= speed_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_car_x
        assign car_x[g*X_W +: X_W] = car_x_q[g];
    end

    assign busy    = busy_q;
    assign running = running_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler: walks through reset, single sweeps,
// wrap-around, back-to-back sweeps, overrun, pause and mid-sweep config/reset.
module tb_lane_scheduler;

    localparam int NUM_LANES = 4;
    localparam int SCREEN_W  = 640;
    localparam int X_W       = 10;
    localparam int SPEED_W   = 4;

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic                       pause;
    logic                       frame_tick;
    logic                       cfg_we;
    logic [1:0]                 cfg_lane;
    logic [SPEED_W-1:0]         cfg_speed;
    logic                       cfg_dir;
    logic [NUM_LANES*X_W-1:0]   car_x;
    logic                       busy;
    logic                       running;
    logic                       overrun;

    int tests_run;
    int tests_failed;
    int busy_cycles;

    lane_scheduler #(
        .NUM_LANES(NUM_LANES),
        .SCREEN_W (SCREEN_W),
        .X_W      (X_W),
        .SPEED_W  (SPEED_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .frame_tick(frame_tick),
        .cfg_we    (cfg_we),
        .cfg_lane  (cfg_lane),
        .cfg_speed (cfg_speed),
        .cfg_dir   (cfg_dir),
        .car_x     (car_x),
        .busy      (busy),
        .running   (running),
        .overrun   (overrun)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive start/tick as one-cycle pulses and pause as a level across one edge.
    task automatic applyStimulus(input logic st, input logic tk, input logic ps);
        start      = st;
        frame_tick = tk;
        pause      = ps;
        @(posedge clk);
        #1;
        start      = 1'b0;
        frame_tick = 1'b0;
    endtask

    // One-cycle lane configuration write.
    task automatic cfgWrite(input logic [1:0] lane, input logic [SPEED_W-1:0] spd, input logic dir);
        cfg_we    = 1'b1;
        cfg_lane  = lane;
        cfg_speed = spd;
        cfg_dir   = dir;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
    endtask

    // Single tick followed by enough cycles for the sweep to finish.
    task automatic sweepTick();
        applyStimulus(1'b0, 1'b1, 1'b0);
        cycles(NUM_LANES);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkLanes(input string tag, input int e0, input int e1, input int e2, input int e3);
        checkOutput({tag, "_x0"}, 32'(car_x[0*X_W +: X_W]), 32'(e0));
        checkOutput({tag, "_x1"}, 32'(car_x[1*X_W +: X_W]), 32'(e1));
        checkOutput({tag, "_x2"}, 32'(car_x[2*X_W +: X_W]), 32'(e2));
        checkOutput({tag, "_x3"}, 32'(car_x[3*X_W +: X_W]), 32'(e3));
    endtask

    // Directed scenario sequence.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        pause        = 1'b0;
        frame_tick   = 1'b0;
        cfg_we       = 1'b0;
        cfg_lane     = '0;
        cfg_speed    = '0;
        cfg_dir      = 1'b0;

        // Reset layout and tick ignored in IDLE
        cycles(2);
        rst = 1'b0;
        checkLanes("reset", 0, 160, 320, 480);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_running", 32'(running), 0);
        checkOutput("reset_overrun", 32'(overrun), 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cycles(4);
        checkLanes("idle_tick", 0, 160, 320, 480);
        checkOutput("idle_running", 32'(running), 0);

        // Start, then left wrap of lane 0 to 638
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_running", 32'(running), 1);
        cfgWrite(2'd0, 4'd2, 1'b1);
        sweepTick();
        checkLanes("wrap_left", 638, 161, 321, 481);

        // Right wrap 638+5 -> 3 with per-lane timing and busy width
        cfgWrite(2'd0, 4'd5, 1'b0);
        busy_cycles = 0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        busy_cycles += int'(busy);
        checkOutput("T_x0", 32'(car_x[0 +: X_W]), 638);
        cycles(1);
        busy_cycles += int'(busy);
        checkOutput("T1_x0", 32'(car_x[0 +: X_W]), 3);
        checkOutput("T1_x1", 32'(car_x[X_W +: X_W]), 161);
        cycles(1);
        busy_cycles += int'(busy);
        checkOutput("T2_x1", 32'(car_x[X_W +: X_W]), 162);
        checkOutput("T2_x2", 32'(car_x[2*X_W +: X_W]), 321);
        cycles(1);
        busy_cycles += int'(busy);
        checkOutput("T3_x2", 32'(car_x[2*X_W +: X_W]), 322);
        checkOutput("T3_x3", 32'(car_x[3*X_W +: X_W]), 481);
        cycles(1);
        busy_cycles += int'(busy);
        checkOutput("T4_x3", 32'(car_x[3*X_W +: X_W]), 482);
        checkOutput("T4_busy", 32'(busy), 0);
        checkOutput("T4_running", 32'(running), 1);
        checkOutput("busy_width_1", 32'(busy_cycles), 4);

        // Lane 1 leftwards at 15 for 11 ticks, lane 3 stationary
        cfgWrite(2'd1, 4'd15, 1'b1);
        cfgWrite(2'd3, 4'd0, 1'b0);
        repeat (11) sweepTick();
        checkLanes("eleven_ticks", 58, 637, 333, 482);

        // Right sum exactly SCREEN_W wraps to 0
        cfgWrite(2'd1, 4'd3, 1'b0);
        sweepTick();
        checkLanes("wrap_exact", 63, 0, 334, 482);

        // Second tick during sweep -> back-to-back sweep
        busy_cycles = 0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        busy_cycles += int'(busy);
        applyStimulus(1'b0, 1'b1, 1'b0);
        busy_cycles += int'(busy);
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            busy_cycles += int'(busy);
        end
        checkOutput("busy_width_2", 32'(busy_cycles), 8);
        checkOutput("b2b_running", 32'(running), 1);
        checkOutput("b2b_overrun", 32'(overrun), 0);
        checkLanes("b2b", 73, 6, 336, 482);

        // Third tick in one sweep -> overrun, only two sweeps applied
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cycles(8);
        checkOutput("ovr_set", 32'(overrun), 1);
        checkOutput("ovr_busy", 32'(busy), 0);
        checkLanes("ovr", 83, 12, 338, 482);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovr_clear", 32'(overrun), 0);
        checkOutput("ovr_running", 32'(running), 1);

        // Pause wins over same-cycle tick; ticks ignored while paused
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("pause_running", 32'(running), 0);
        checkOutput("pause_busy", 32'(busy), 0);
        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            cycles(4);
        end
        checkLanes("paused", 83, 12, 338, 482);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("unpause_running", 32'(running), 1);
        sweepTick();
        checkLanes("unpaused", 88, 15, 339, 482);

        // Pause mid-sweep: sweep completes, then PAUSED
        applyStimulus(1'b0, 1'b1, 1'b0);
        pause = 1'b1;
        cycles(4);
        checkOutput("midpause_run", 32'(running), 1);
        cycles(1);
        checkOutput("midpause_paused", 32'(running), 0);
        checkLanes("midpause", 93, 18, 340, 482);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midpause_resume", 32'(running), 1);

        // Config during sweep: lane 3 ahead of sweep uses new, lane 2 at sweep uses old
        applyStimulus(1'b0, 1'b1, 1'b0);
        cycles(1);
        cfgWrite(2'd3, 4'd7, 1'b0);
        cfgWrite(2'd2, 4'd10, 1'b0);
        cycles(1);
        checkLanes("cfg_sweep", 98, 21, 341, 489);
        sweepTick();
        checkLanes("cfg_next", 103, 24, 351, 496);

        // Reset mid-sweep discards everything
        applyStimulus(1'b0, 1'b1, 1'b0);
        cycles(1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        checkLanes("rst_mid", 0, 160, 320, 480);
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_running", 32'(running), 0);
        checkOutput("rst_mid_overrun", 32'(overrun), 0);
        cycles(4);
        checkLanes("rst_settled", 0, 160, 320, 480);
        applyStimulus(1'b1, 1'b0, 1'b0);
        sweepTick();
        checkLanes("rst_defaults", 1, 161, 321, 481);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
